tt_sel_seq: RTL
===============

# tt_sel_seq

Parametrised design-selection sequencer for the multiplexer controller. It samples the asynchronous select pads (`sel_rst_n`, `sel_inc`, `ena`) and counts `sel_inc` pulses into a {mux, block} address. It commits that address to the spine with break-before-make enable sequencing, so the address never changes while enable is high. It generalises legacy pulse selection to arbitrary power-of-two branch and block counts, and adds overflow detection plus an optional serial readback of the committed address.

## Interface
Parameters:
- `N_MUX`, default 16: number of branch muxes. Must be a power of two, ≥2.
- `N_BLK`, default 16: user blocks per branch. Must be a power of two, ≥2.
- `SYNC_STAGES`, default 2: pad synchroniser depth, ≥2.
- `GUARD_CYC`, default 4: enable-low guard cycles before an address change, ≥1.
- Derived localparam `ADDR_W` = clog2(N_MUX) + clog2(N_BLK).

Ports:
- `clk` — in, 1 — controller clock.
- `rst_n` — in, 1 — asynchronous, active-low reset.
- `pad_sel_rst_n` — in, 1 — async pad input; low clears the select counter.
- `pad_sel_inc` — in, 1 — async pad input; each rising edge increments the counter.
- `pad_ena` — in, 1 — async pad input; requests the selected design be enabled.
- `spine_addr` — out, ADDR_W — committed address: {mux index (MSBs), block index (LSBs)}.
- `spine_ena` — out, 1 — enable for the committed address.
- `sel_err` — out, 1 — sticky flag: increment was attempted at the maximum count.
- `busy` — out, 1 — high in LOAD or DRAIN.
- `rb_out` — out, 1 — serial readback data.
- `rb_oe_n` — out, 1 — readback output enable, active-low.

## Operation
- **Synchronisers.** Each pad passes through SYNC_STAGES flops, giving `sel_rst_s`, `inc_s` and `ena_s`. All reset to 0.
- **Counter `cnt`** (ADDR_W bits):
  - `sel_rst_s`=0: `cnt`←0 and `sel_err`←0.
  - Otherwise, on an `inc_s` rising edge: `cnt`←`cnt`+1.
  - At `cnt` = 2^ADDR_W−1 the counter saturates and `sel_err`←1. It never wraps.
  - If a clear and an increment edge occur in the same cycle, the clear wins.
- **FSM states:**
  - IDLE: `spine_ena`=0. Go to LOAD when `ena_s`=1, `sel_rst_s`=1 and `sel_err`=0.
  - LOAD: `spine_addr`←`cnt`. Always go to ACTIVE after one cycle.
  - ACTIVE: `spine_ena`=1. Go to DRAIN if `ena_s`=0, `sel_rst_s`=0, or `cnt`≠`spine_addr`.
  - DRAIN: `spine_ena`=0 and `spine_addr` is held. The guard counter loads GUARD_CYC on entry and decrements each cycle. Go to IDLE when it reaches 1.
- **Reset values:** `spine_addr`=0, `spine_ena`=0, `sel_err`=0, `busy`=0, `rb_out`=0, `rb_oe_n`=1, state IDLE. Assertion of `rst_n` mid-operation drops all outputs asynchronously.
- **Invariant:** `spine_addr` changes only in LOAD, so it is never modified while `spine_ena`=1.

## Timing
- Pad to synchronised signal: SYNC_STAGES cycles.
- `ena_s` first high in IDLE at cycle t:
  - cycle t+1 is LOAD;
  - `spine_addr` is valid at t+2;
  - `spine_ena` rises at t+2.
- ACTIVE exit condition true at cycle t: `spine_ena` falls at t+1 and DRAIN lasts GUARD_CYC cycles. The earliest next `spine_ena` rise is t+GUARD_CYC+3.
- `inc_s` edge while ACTIVE with `ena_s` held high: the sequence is drain, then reload, then re-enable automatically with the new address.
- All outputs are registered. There are no combinational paths from pads to outputs.

## Configuration
- `TT_SEL_READBACK_EN` defined:
  - On each entry to ACTIVE, the block shifts out a frame of ADDR_W+1 bits, one bit per clk: a start bit 1, then `spine_addr` MSB-first.
  - `rb_oe_n`=0 only while the frame is being sent.
  - Leaving ACTIVE aborts the frame: `rb_oe_n`←1 and `rb_out`←0.
- `TT_SEL_READBACK_EN` undefined: the ports still exist, tied `rb_out`=0 and `rb_oe_n`=1, and there are no shift-register flops.

## Structure
- Package `tt_sel_pkg` contains:
  - the state encoding (IDLE/LOAD/ACTIVE/DRAIN);
  - a clog2 helper;
  - the elaboration checks for power-of-two N_MUX/N_BLK and for GUARD_CYC≥1.
- Sub-module `tt_sel_sync`: an N-stage reset-to-0 synchroniser, instantiated three times.

## Test plan
- **Basic select.** Reset; hold `pad_sel_rst_n`=1 and give 19 `inc` pulses; raise `pad_ena`. Expect `spine_addr`=0x13 (mux 1, blk 3) and `spine_ena` rising SYNC_STAGES+2 cycles after the pad edge.
- **Re-select while active.** With the design active, give 1 extra `inc` pulse. Expect `spine_ena` low for exactly GUARD_CYC+2 cycles, then `spine_addr`=0x14 with `spine_ena`=1. `spine_addr` must never change while `spine_ena`=1.
- **Saturation.** Give 257 pulses (defaults). Expect `cnt`=0xFF, `sel_err`=1, and `pad_ena`=1 leaving `spine_ena` at 0. Pulsing `pad_sel_rst_n` low clears both.
- **Clear/increment collision.** Drive a `sel_rst` low and an `inc` edge in the same synchronised cycle. Expect `cnt`=0.
- **Async reset.** Assert `rst_n` low while ACTIVE. Expect `spine_ena`=0, `spine_addr`=0 and `rb_oe_n`=1 immediately, without a clk edge.
- **Readback (`TT_SEL_READBACK_EN`).** Select 0xA5. Expect `rb_oe_n` low for 9 cycles and the `rb_out` sequence 1,1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/tt_sel_pkg.sv
// tt_sel_pkg: shared state encoding, width helper and parameter legality
// checks for the design-selection sequencer.
package tt_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } sel_state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // True when the sequencer parameter set is legal.
    function automatic bit params_ok(input int n_mux, input int n_blk,
                                     input int sync_stages, input int guard_cyc);
        return is_pow2(n_mux) && is_pow2(n_blk) &&
               (sync_stages >= 2) && (guard_cyc >= 1);
    endfunction

endpackage

// File: rtl/tt_sel_sync.sv
// tt_sel_sync: STAGES-deep level synchroniser for an asynchronous pad,
// cleared to 0 by the controller reset.
module tt_sel_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    // Shift the pad level through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/tt_sel_seq.sv
// tt_sel_seq: counts sel_inc pulses into a {mux, block} address and commits
// it to the spine with break-before-make enable sequencing.
// Optional serial readback of the committed address: TT_SEL_READBACK_EN.
module tt_sel_seq
    import tt_sel_pkg::*;
#(
    parameter int N_MUX       = 16,
    parameter int N_BLK       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int GUARD_CYC   = 4,
    localparam int ADDR_W     = clog2(N_MUX) + clog2(N_BLK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_sel_rst_n,
    input  logic              pad_sel_inc,
    input  logic              pad_ena,
    output logic [ADDR_W-1:0] spine_addr,
    output logic              spine_ena,
    output logic              sel_err,
    output logic              busy,
    output logic              rb_out,
    output logic              rb_oe_n
);

    localparam int GUARD_W = clog2(GUARD_CYC + 1);
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    if (!params_ok(N_MUX, N_BLK, SYNC_STAGES, GUARD_CYC)) begin : g_param_check
        $error("tt_sel_seq: N_MUX/N_BLK must be powers of two >= 2, SYNC_STAGES >= 2, GUARD_CYC >= 1");
    end

    logic               sel_rst_s;
    logic               inc_s;
    logic               ena_s;
    logic               inc_d;
    logic               inc_rise;
    logic [ADDR_W-1:0]  cnt;
    sel_state_t         state;
    logic [GUARD_W-1:0] guard;
    logic               exit_active;
    logic               start_ok;

    tt_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_sel_rst_n),
        .q     (sel_rst_s)
    );

    tt_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_sel_inc),
        .q     (inc_s)
    );

    tt_sel_sync #(.STAGES(SYNC_STAGES)) u_sync_ena (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_ena),
        .q     (ena_s)
    );

    assign inc_rise    = inc_s & ~inc_d;
    assign exit_active = !ena_s || !sel_rst_s || (cnt != spine_addr);
    assign start_ok    = ena_s && sel_rst_s && !sel_err;

    // Saturating select counter; a clear outranks a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sel_err <= 1'b0;
            inc_d   <= 1'b0;
        end else begin
            inc_d <= inc_s;
            if (!sel_rst_s) begin
                cnt     <= '0;
                sel_err <= 1'b0;
            end else if (inc_rise) begin
                if (cnt == CNT_MAX) begin
                    sel_err <= 1'b1;
                end else begin
                    cnt <= cnt + ADDR_W'(1);
                end
            end
        end
    end

    // Commit sequencer: the address only moves in LOAD, with enable low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            spine_addr <= '0;
            spine_ena  <= 1'b0;
            busy       <= 1'b0;
            guard      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    spine_ena <= 1'b0;
                    if (start_ok) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    spine_addr <= cnt;
                    spine_ena  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (exit_active) begin
                        spine_ena <= 1'b0;
                        busy      <= 1'b1;
                        guard     <= GUARD_W'(GUARD_CYC);
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (guard == GUARD_W'(1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        guard <= guard - GUARD_W'(1);
                    end
                end
                default: begin
                    spine_ena <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TT_SEL_READBACK_EN
    localparam int RB_W = clog2(ADDR_W + 1);

    logic [ADDR_W-1:0] rb_sr;
    logic [RB_W-1:0]   rb_rem;

    // Start bit goes out with the enable rise, then the address MSB-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_sr   <= '0;
            rb_rem  <= '0;
            rb_out  <= 1'b0;
            rb_oe_n <= 1'b1;
        end else if (state == ST_LOAD) begin
            rb_sr   <= cnt;
            rb_rem  <= RB_W'(ADDR_W);
            rb_out  <= 1'b1;
            rb_oe_n <= 1'b0;
        end else if ((state == ST_ACTIVE) && !exit_active && (rb_rem != '0)) begin
            rb_out  <= rb_sr[ADDR_W-1];
            rb_sr   <= rb_sr << 1;
            rb_rem  <= rb_rem - RB_W'(1);
            rb_oe_n <= 1'b0;
        end else begin
            rb_rem  <= '0;
            rb_out  <= 1'b0;
            rb_oe_n <= 1'b1;
        end
    end
`else
    assign rb_out  = 1'b0;
    assign rb_oe_n = 1'b1;
`endif

endmodule
